q_requant_stream: RTL and testbench

//  Streaming fixed-point requantizer: narrows wide Q-format accumulator values
//  (e.g. QK^T/PV dot-product sums) to a narrower Q-format for the next stage.
//  - Drops fractional bits with round-half-up.
//  - Saturates the integer part.
//  - 2-stage valid/ready pipeline with full backpressure.
//  - Counts saturation events.

---
 rtl/q_requant_stream.sv | 112 +++++++++++
 tb/tb_q_requant_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/q_requant_stream.sv
// Streaming fixed-point requantizer: rounds wide Q-format samples half-up to a
// narrower Q-format, saturates the integer part and counts saturated deliveries.
module q_requant_stream #(
   parameter  int IN_I  = 15,
   parameter  int IN_F  = 16,
   parameter  int OUT_I = 7,
   parameter  int OUT_F = 8,
   parameter  int CNT_W = 16,
   localparam int W_IN  = IN_I + IN_F + 1,
   localparam int W_OUT = OUT_I + OUT_F + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] out_data,
   output logic             out_last,
   output logic             out_sat,
   input  logic             clear_stats,
   output logic [CNT_W-1:0] sat_count,
   output logic             sat_sticky
);

   localparam int SH = IN_F - OUT_F;
   localparam int RW = W_IN - SH + 1;
   localparam logic [W_IN:0] HALF = (SH > 0) ? ((W_IN+1)'(1) << ((SH > 0) ? (SH - 1) : 0)) : '0;
   localparam logic [RW-1:0] MAXV = {{(RW-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
   localparam logic [RW-1:0] MINV = {{(RW-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

   logic             s1_v;
   logic             s1_last;
   logic [RW-1:0]    s1_r;
   logic             s2_v;
   logic             s1_adv;
   logic             s2_adv;
   logic [W_IN:0]    rnd_sum;
   logic [RW-1:0]    rnd_r;
   logic             sat_hi;
   logic             sat_lo;
   logic [W_OUT-1:0] sat_data;
   logic             sat_xfer;

   // Handshake: a beat moves when valid && ready; a stage loads when it is
   // empty or its consumer takes its beat this cycle, so in_ready is the only
   // combinational path from out_ready.
   assign s2_adv    = !s2_v || out_ready;
   assign s1_adv    = !s1_v || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_v;

   // One guard bit above the sign keeps the half-LSB add from overflowing.
   always_comb begin
      rnd_sum = {in_data[W_IN-1], in_data} + HALF;
      rnd_r   = RW'($signed(rnd_sum) >>> SH);
   end

   always_comb begin
      sat_hi   = $signed(s1_r) > $signed(MAXV);
      sat_lo   = $signed(s1_r) < $signed(MINV);
      sat_data = s1_r[W_OUT-1:0];
      if (sat_hi) sat_data = MAXV[W_OUT-1:0];
      if (sat_lo) sat_data = MINV[W_OUT-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_v    <= 1'b0;
         s1_last <= 1'b0;
         s1_r    <= '0;
      end else if (s1_adv) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_last <= in_last;
            s1_r    <= rnd_r;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s2_v     <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         out_sat  <= 1'b0;
      end else if (s2_adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            out_data <= sat_data;
            out_last <= s1_last;
            out_sat  <= sat_hi || sat_lo;
         end
      end
   end

   assign sat_xfer = s2_v && out_ready && out_sat;

   // Clear has priority over a coincident saturated delivery.
   always_ff @(posedge clock) begin
      if (reset || clear_stats) begin
         sat_count  <= '0;
         sat_sticky <= 1'b0;
      end else if (sat_xfer) begin
         sat_sticky <= 1'b1;
         if (sat_count != '1) sat_count <= sat_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_q_requant_stream.sv
// Bench for q_requant_stream: directed vector table through a scoreboard plus
// hand-written backpressure, counter-saturation, clear and reset sequences.
module tb_q_requant_stream;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        out_sat;
   logic        clear_stats;
   logic [15:0] sat_count;
   logic        sat_sticky;

   typedef struct {
      logic [31:0] din;
      logic [15:0] dout;
      logic        sat;
   } vec_t;

   vec_t        vecs[12];
   logic [17:0] exp_q[$];
   logic [17:0] mon_e;
   logic [17:0] held;
   logic        held_v = 1'b0;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          n_out  = 0;
   int          n_sat  = 0;
   bit          bp_en  = 1'b0;

   q_requant_stream dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_sat(out_sat),
      .clear_stats(clear_stats), .sat_count(sat_count), .sat_sticky(sat_sticky)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clock) begin
      if (bp_en) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard: every delivered beat must match the oldest accepted one.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got %h expected none", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(mon_e[15:0]));
            chk("out_sat", 32'(out_sat), 32'(mon_e[16]));
            chk("out_last", 32'(out_last), 32'(mon_e[17]));
            n_out++;
         end
      end
      if (!reset && out_valid && !out_ready) begin
         if (held_v) chk("stall_hold", 32'({out_last, out_sat, out_data}), 32'(held));
         held   = {out_last, out_sat, out_data};
         held_v = 1'b1;
      end else begin
         held_v = 1'b0;
      end
   end

   task automatic send(input logic [31:0] d, input logic l, input logic [17:0] e);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clock);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clock);
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      vecs[0]  = '{32'h0001_8000, 16'h0180, 1'b0};
      vecs[1]  = '{32'hFFFE_8000, 16'hFE80, 1'b0};
      vecs[2]  = '{32'h0000_0080, 16'h0001, 1'b0};
      vecs[3]  = '{32'hFFFF_FF80, 16'h0000, 1'b0};
      vecs[4]  = '{32'h0000_007F, 16'h0000, 1'b0};
      vecs[5]  = '{32'h0100_0000, 16'h7FFF, 1'b1};
      vecs[6]  = '{32'h8000_0000, 16'h8000, 1'b1};
      vecs[7]  = '{32'h007F_FFFF, 16'h7FFF, 1'b1};
      vecs[8]  = '{32'hFFFF_FF7F, 16'hFFFF, 1'b0};
      vecs[9]  = '{32'h007F_FF7F, 16'h7FFF, 1'b0};
      vecs[10] = '{32'hFF80_0000, 16'h8000, 1'b0};
      vecs[11] = '{32'hFF7F_FF7F, 16'h8000, 1'b1};

      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b0; clear_stats = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);
      chk("rst_sat_count", 32'(sat_count), 32'd0);
      chk("rst_sat_sticky", 32'(sat_sticky), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1 out_ready = 1'b1;

      // Two-cycle latency on an isolated sample.
      send(32'h0003_0000, 1'b0, {1'b0, 1'b0, 16'h0300});
      @(negedge clock);
      chk("latency_c1", 32'(out_valid), 32'd0);
      @(negedge clock);
      chk("latency_c2", 32'(out_valid), 32'd1);
      @(posedge clock);
      #1;

      // Vector table streamed back to back.
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].din, 1'b0, {1'b0, vecs[i].sat, vecs[i].dout});
         if (vecs[i].sat) n_sat++;
      end
      drain();
      chk("table_sat_count", 32'(sat_count), 32'(n_sat));
      chk("table_sat_sticky", 32'(sat_sticky), 32'd1);

      // Random backpressure with an end-of-row tag on the tenth beat.
      n_out = 0;
      bp_en = 1'b1;
      for (int i = 0; i < 10; i++)
         send(32'(i) << 16, i == 9, {i == 9, 1'b0, 16'(i) << 8});
      drain();
      bp_en = 1'b0;
      @(posedge clock);
      #1 out_ready = 1'b1;
      chk("bp_out_count", 32'(n_out), 32'd10);

      // Drive the counter to all-ones, then confirm it holds.
      for (int i = n_sat; i < 65535; i++)
         send(32'h7FFF_FFFF, 1'b0, {1'b0, 1'b1, 16'h7FFF});
      drain();
      chk("cnt_at_max", 32'(sat_count), 32'hFFFF);
      send(32'h8000_0001, 1'b0, {1'b0, 1'b1, 16'h8000});
      drain();
      chk("cnt_hold_max", 32'(sat_count), 32'hFFFF);
      chk("sticky_at_max", 32'(sat_sticky), 32'd1);

      // Clear coinciding with a saturated delivery.
      out_ready = 1'b0;
      send(32'h7FFF_FFFF, 1'b0, {1'b0, 1'b1, 16'h7FFF});
      begin
         int n = 0;
         @(negedge clock);
         while (!out_valid && n < 20) begin
            n++;
            @(negedge clock);
         end
         chk("clr_wait_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clock);
      #1 out_ready = 1'b1; clear_stats = 1'b1;
      @(posedge clock);
      #1 clear_stats = 1'b0;
      chk("clr_sat_count", 32'(sat_count), 32'd0);
      chk("clr_sat_sticky", 32'(sat_sticky), 32'd0);
      drain();

      // Reset with both stages full and the output stalled.
      send(32'h7FFF_FFFF, 1'b0, {1'b0, 1'b1, 16'h7FFF});
      drain();
      chk("pre_rst_count", 32'(sat_count), 32'd1);
      out_ready = 1'b0;
      send(32'h0001_0000, 1'b0, {1'b0, 1'b0, 16'h0100});
      send(32'h7FFF_0000, 1'b1, {1'b1, 1'b1, 16'h7FFF});
      @(negedge clock);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      exp_q.delete();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_sat_count", 32'(sat_count), 32'd0);
      chk("mid_rst_sticky", 32'(sat_sticky), 32'd0);
      out_ready = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      send(32'h0002_0000, 1'b1, {1'b1, 1'b0, 16'h0200});
      drain();
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
